fadd_result_sink: RTL and testbench



---
 rtl/fadd_result_sink_if.sv | 28 ++
 rtl/fadd_result_sink.sv | 161 ++++++++++++++++
 tb/tb_fadd_result_sink.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_result_sink_if.sv
// Control/result bundle between the fadd issuer, the fadd unit and writeback.
// The sink uses the slave view; the environment (issuer + fadd + writeback) uses the master view.
interface fadd_result_sink_if #(
   parameter int TAG_W = 5
) ();
   logic             issue_valid;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_ready;
   logic             fadd_enable_in;
   logic             fadd_enable_out;
   logic [31:0]      fadd_y;
   logic             fadd_ovf;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;
   logic             wb_ovf;

   modport slave (
      input  issue_valid, issue_tag, fadd_enable_out, fadd_y, fadd_ovf, wb_ready,
      output issue_ready, fadd_enable_in, wb_valid, wb_tag, wb_data, wb_ovf
   );

   modport master (
      output issue_valid, issue_tag, fadd_enable_out, fadd_y, fadd_ovf, wb_ready,
      input  issue_ready, fadd_enable_in, wb_valid, wb_tag, wb_data, wb_ovf
   );
endinterface

// File: rtl/fadd_result_sink.sv
// Consumer end of the pipelined fadd: issue credits, tag shadow pipeline, FWFT result FIFO.
// Optional macro FADD_SINK_OVF_TRAP_EN enables the sticky overflow trap that blocks new issue.
module fadd_result_sink #(
   parameter int NSTAGE = 2,
   parameter int TAG_W  = 5,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   fadd_result_sink_if.slave      bus,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   err_seq,
   output logic                   ovf_trap
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int ENT_W = TAG_W + 33;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   logic              fire;
   logic              push;
   logic              drop;
   logic              stray;
   logic              pop;
   logic              avail;
   logic              head_v;
   logic [TAG_W-1:0]  head_tag;

   logic [NSTAGE-1:0] sv_q;
   logic [TAG_W-1:0]  stag_q [NSTAGE];

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [OCC_W-1:0]  cnt_q, cnt_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              err_q, err_d;
   logic              trap_q;

   logic              wb_valid_q;
   logic [TAG_W-1:0]  wb_tag_q;
   logic [31:0]       wb_data_q;
   logic              wb_ovf_q;

   // Occupancy counts in-flight ops too, so a granted credit always has a FIFO slot waiting.
   assign bus.issue_ready    = (occ_q < DEPTH_C) & ~rst & ~trap_q;
   assign fire               = bus.issue_valid & bus.issue_ready;
   assign bus.fadd_enable_in = fire;

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) begin
                  sv_q[0]   <= 1'b0;
                  stag_q[0] <= '0;
               end else begin
                  sv_q[0]   <= fire;
                  stag_q[0] <= bus.issue_tag;
               end
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (rst) begin
                  sv_q[gi]   <= 1'b0;
                  stag_q[gi] <= '0;
               end else begin
                  sv_q[gi]   <= sv_q[gi-1];
                  stag_q[gi] <= stag_q[gi-1];
               end
            end
         end
      end
   endgenerate

   assign head_v   = sv_q[NSTAGE-1];
   assign head_tag = stag_q[NSTAGE-1];
   assign push     = head_v & bus.fadd_enable_out;
   assign drop     = head_v & ~bus.fadd_enable_out;
   assign stray    = ~head_v & bus.fadd_enable_out;
   assign pop      = wb_valid_q & bus.wb_ready;

   // Only entries written before this edge are readable; a same-edge push shows up one cycle later.
   assign avail = (cnt_q != OCC_W'(pop));

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + OCC_W'(push) - OCC_W'(pop);
      occ_d = occ_q + OCC_W'(fire) - OCC_W'(pop) - OCC_W'(drop);
      err_d = err_q;
      if (push) begin
         wr_d = wr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_d = rd_q + PTR_W'(1);
      end
      if (drop | stray) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         occ_q <= '0;
         err_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         occ_q <= occ_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_q] <= {head_tag, bus.fadd_y, bus.fadd_ovf};
      end
   end

   // Registered read at the next head address gives first-word-fall-through with flopped outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_tag_q   <= '0;
         wb_data_q  <= '0;
         wb_ovf_q   <= 1'b0;
      end else begin
         wb_valid_q <= avail;
         if (avail) begin
            {wb_tag_q, wb_data_q, wb_ovf_q} <= mem[rd_d];
         end
      end
   end

`ifdef FADD_SINK_OVF_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_q <= 1'b0;
      end else if (push & bus.fadd_ovf) begin
         trap_q <= 1'b1;
      end
   end
`else
   assign trap_q = 1'b0;
`endif

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_tag   = wb_tag_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_ovf   = wb_ovf_q;
   assign occupancy    = occ_q;
   assign err_seq      = err_q;
   assign ovf_trap     = trap_q;

endmodule

// File: tb/tb_fadd_result_sink.sv
// Bench for fadd_result_sink: acts as issuer, fadd unit and writeback, and compares every
// cycle against a queue-based model of credits, in-flight ops and the result FIFO.
module tb_fadd_result_sink;
   localparam int NSTAGE = 2;
   localparam int TAG_W  = 5;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst;
   logic [$clog2(DEPTH):0] occupancy;
   logic err_seq;
   logic ovf_trap;

   fadd_result_sink_if #(.TAG_W(TAG_W)) bus ();

   fadd_result_sink #(.NSTAGE(NSTAGE), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .occupancy (occupancy),
      .err_seq   (err_seq),
      .ovf_trap  (ovf_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [TAG_W-1:0] tag; int land; } infl_t;
   typedef struct { logic [TAG_W-1:0] tag; logic [31:0] y; logic ovf; int pushed; } ent_t;
   typedef struct { int drive; logic [31:0] y; logic ovf; bit sup; } fop_t;

   infl_t infl_q[$];
   ent_t  fifo_q[$];
   fop_t  fop_q[$];

   bit          m_err, m_trap, m_valid;
   int          cyc, n_fire;
   int          n_vec, n_bad;
   bit          force_en, suppress_next, spurious_next;
   logic [31:0] force_y;
   logic        force_ovf;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: pre-edge checks of combinational outputs, model update, fadd drive, post-edge checks.
   task automatic tick();
      bit               er, fire, pop, en, ov;
      logic [TAG_W-1:0] tg;
      logic [31:0]      y;
      int               k;
      #1;
      er = ((infl_q.size() + fifo_q.size()) < DEPTH) && !rst && !m_trap;
      chk("issue_ready", {39'd0, bus.issue_ready}, {39'd0, er});
      fire = bus.issue_valid && er;
      chk("fadd_enable_in", {39'd0, bus.fadd_enable_in}, {39'd0, fire});
      pop = m_valid && bus.wb_ready;
      tg  = bus.issue_tag;
      k   = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         infl_q.delete();
         fifo_q.delete();
         m_err  = 0;
         m_trap = 0;
      end else begin
         if (pop) void'(fifo_q.pop_front());
         if (infl_q.size() > 0 && infl_q[0].land == k) begin
            if (bus.fadd_enable_out) begin
               fifo_q.push_back('{tag: infl_q[0].tag, y: bus.fadd_y, ovf: bus.fadd_ovf, pushed: k});
`ifdef FADD_SINK_OVF_TRAP_EN
               if (bus.fadd_ovf) m_trap = 1;
`endif
            end else begin
               m_err = 1;
            end
            void'(infl_q.pop_front());
         end else if (bus.fadd_enable_out) begin
            m_err = 1;
         end
         if (fire) begin
            infl_q.push_back('{tag: tg, land: k + NSTAGE});
            n_fire++;
         end
      end
      // fadd unit: answers NSTAGE cycles after enable_in, independent of the sink's reset
      if (fire) begin
         fop_q.push_back('{drive: k + NSTAGE - 1,
                           y: force_en ? force_y : $urandom,
                           ovf: force_en ? force_ovf : 1'b0,
                           sup: suppress_next});
         suppress_next = 0;
      end
      en = 0;
      y  = $urandom;
      ov = 0;
      if (fop_q.size() > 0 && fop_q[0].drive == k + 1 - 1 + 0 && fop_q[0].drive == cyc - 1 + (NSTAGE > 0 ? 0 : 0)) begin
         en = !fop_q[0].sup;
         y  = fop_q[0].y;
         ov = fop_q[0].ovf;
         void'(fop_q.pop_front());
      end
      if (spurious_next) begin
         en = 1;
         spurious_next = 0;
      end
      bus.fadd_enable_out = en;
      bus.fadd_y          = y;
      bus.fadd_ovf        = ov;
      m_valid = (fifo_q.size() > 0) && (fifo_q[0].pushed < k);
      chk("wb_valid", {39'd0, bus.wb_valid}, {39'd0, m_valid});
      if (m_valid) begin
         chk("wb_tag", {35'd0, bus.wb_tag}, {35'd0, fifo_q[0].tag});
         chk("wb_data", {8'd0, bus.wb_data}, {8'd0, fifo_q[0].y});
         chk("wb_ovf", {39'd0, bus.wb_ovf}, {39'd0, fifo_q[0].ovf});
      end
      chk("occupancy", 40'(occupancy), 40'(infl_q.size() + fifo_q.size()));
      chk("err_seq", {39'd0, err_seq}, {39'd0, m_err});
      chk("ovf_trap", {39'd0, ovf_trap}, {39'd0, m_trap});
   endtask

   task automatic issue(input int tag);
      bus.issue_valid = 1'b1;
      bus.issue_tag   = TAG_W'(tag);
      tick();
      bus.issue_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_bad = 0; cyc = 0; n_fire = 0;
      m_err = 0; m_trap = 0; m_valid = 0;
      force_en = 0; force_y = '0; force_ovf = 0;
      suppress_next = 0; spurious_next = 0;
      rst = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_tag = '0; bus.wb_ready = 1'b0;
      bus.fadd_enable_out = 1'b0; bus.fadd_y = '0; bus.fadd_ovf = 1'b0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_wb_tag", {35'd0, bus.wb_tag}, 40'd0);
      chk("rst_wb_data", {8'd0, bus.wb_data}, 40'd0);
      chk("rst_wb_ovf", {39'd0, bus.wb_ovf}, 40'd0);
      chk("rst_occ", 40'(occupancy), 40'd0);

      // Single op, tag 7, y=3.0: wb_valid appears NSTAGE+1 cycles after issue
      force_en = 1; force_y = 32'h40400000; force_ovf = 0;
      issue(7);
      force_en = 0;
      chk("single_occ_e0", 40'(occupancy), 40'd1);
      tick();
      tick();
      chk("single_lat_e2", {39'd0, bus.wb_valid}, 40'd0);
      tick();
      chk("single_lat_e3", {39'd0, bus.wb_valid}, 40'd1);
      chk("single_tag", {35'd0, bus.wb_tag}, 40'd7);
      chk("single_data", {8'd0, bus.wb_data}, 40'h40400000);
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
      chk("single_occ_pop", 40'(occupancy), 40'd0);

      // Backpressure fill: six requests, only DEPTH fire
      n_fire = 0;
      for (int t = 1; t <= 6; t++) issue(t);
      tick(); tick(); tick();
      chk("bp_fires", 40'(n_fire), 40'd4);
      chk("bp_ready_low", {39'd0, bus.issue_ready}, 40'd0);
      chk("bp_head", {35'd0, bus.wb_tag}, 40'd1);
      bus.wb_ready = 1'b1;
      for (int t = 2; t <= 4; t++) begin
         tick();
         chk("bp_drain_order", {35'd0, bus.wb_tag}, 40'(t));
      end
      tick();
      issue(10); issue(11);
      repeat (5) tick();

      // Three buffered plus one landing while the head is popped
      bus.wb_ready = 1'b0;
      for (int t = 12; t <= 15; t++) issue(t);
      tick();
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
      chk("full_pp_occ", 40'(occupancy), 40'd3);
      chk("full_pp_head", {35'd0, bus.wb_tag}, 40'd13);
      tick();
      bus.wb_ready = 1'b1;
      repeat (5) tick();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         bus.issue_valid = ($urandom_range(0, 3) != 0);
         bus.issue_tag   = TAG_W'($urandom);
         bus.wb_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.issue_valid = 1'b0;
      bus.wb_ready    = 1'b1;
      repeat (8) tick();

      // Missing enable_out for tag 9, then a stray enable_out with nothing in flight
      suppress_next = 1;
      issue(9);
      repeat (4) tick();
      chk("miss_err", {39'd0, err_seq}, 40'd1);
      chk("miss_occ", 40'(occupancy), 40'd0);
      spurious_next = 1;
      tick();
      tick();
      chk("stray_err", {39'd0, err_seq}, 40'd1);
      chk("stray_valid", {39'd0, bus.wb_valid}, 40'd0);

      // Reset with two buffered and two in flight
      bus.wb_ready = 1'b0;
      for (int t = 20; t <= 23; t++) issue(t);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", {39'd0, bus.wb_valid}, 40'd0);
      chk("midrst_occ", 40'(occupancy), 40'd0);
      #1;
      chk("midrst_ready", {39'd0, bus.issue_ready}, 40'd1);
      bus.wb_ready = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < 60; i++) begin
         bus.issue_valid = ($urandom_range(0, 1) != 0);
         bus.issue_tag   = TAG_W'($urandom);
         bus.wb_ready    = ($urandom_range(0, 2) != 0);
         tick();
      end
      bus.issue_valid = 1'b0;
      bus.wb_ready    = 1'b1;
      repeat (8) tick();

      // Overflowing result, tag 3, y=+inf
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wb_ready = 1'b0;
      force_en = 1; force_y = 32'h7f800000; force_ovf = 1;
      issue(3);
      force_en = 0;
      repeat (3) tick();
      chk("ovf_tag", {35'd0, bus.wb_tag}, 40'd3);
      chk("ovf_flag", {39'd0, bus.wb_ovf}, 40'd1);
      chk("ovf_data", {8'd0, bus.wb_data}, 40'h7f800000);
`ifdef FADD_SINK_OVF_TRAP_EN
      chk("ovf_trap_set", {39'd0, ovf_trap}, 40'd1);
      chk("ovf_trap_block", {39'd0, bus.issue_ready}, 40'd0);
`else
      chk("ovf_trap_off", {39'd0, ovf_trap}, 40'd0);
      chk("ovf_ready_on", {39'd0, bus.issue_ready}, 40'd1);
`endif
      bus.wb_ready = 1'b1;
      issue(4);
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
